// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a valid/ready source into instruction memory.
// Bytes are packed little-endian into 32-bit words and written to consecutive
// word addresses starting at byte address 0. The core is held in reset while a
// load is in progress.
module imem_loader #(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      asm_word;
  logic [31:0]      asm_next;
  logic             accept;
  logic             last_word;
  logic             count_ok;

  assign accept    = rx_valid && rx_ready;
  assign last_word = (CNT_W'(word_idx) + CNT_W'(1)) == count;
  assign count_ok  = (word_count != '0) && (word_count <= DEPTH_C);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = count_ok ? RECV : DONE;
      RECV:  if (accept && byte_idx == 2'd3) state_next = WRITE;
      WRITE: state_next = last_word ? DONE : RECV;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs: ready only while collecting bytes
  always_comb begin
    rx_ready = (state == RECV);
  end

  // Drop the incoming byte into its lane of the word being assembled
  always_comb begin
    asm_next = asm_word;
    unique case (byte_idx)
      2'd0: asm_next[7:0]   = rx_data;
      2'd1: asm_next[15:8]  = rx_data;
      2'd2: asm_next[23:16] = rx_data;
      2'd3: asm_next[31:24] = rx_data;
      default: asm_next = asm_word;
    endcase
  end

  // Registered outputs and datapath; we/done are set on the transition into
  // WRITE/DONE so they are high exactly during those states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err <= (word_count > DEPTH_C);
            if (count_ok) begin
              count    <= word_count;
              word_idx <= '0;
              byte_idx <= '0;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we    <= 1'b1;
              waddr <= 32'({word_idx, 2'b00});
              wdata <= asm_next;
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            byte_idx <= '0;
          end
        end
        DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Log of observed memory writes
  int unsigned we_cnt = 0;
  logic [31:0] wa_log [0:127];
  logic [31:0] wd_log [0:127];

  imem_loader #(.MEM_DEPTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record each write pulse mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wa_log[we_cnt[6:0]] = waddr;
      wd_log[we_cnt[6:0]] = wdata;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    logic acc;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      acc = rx_ready;
      tick();
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("handshake_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
  endtask

  task automatic do_start(input logic [5:0] n);
    start      = 1'b1;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {24'b0, rx_ready, we, busy, cpu_hold, done, err, 2'b0}, 32'd0);
    chk({tag, "_waddr"}, waddr, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
  endtask

  int unsigned base;
  logic [31:0] w3 [0:2];
  int unsigned gaps [0:11];
  logic [31:0] fw;

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    w3[0] = 32'h00500093; w3[1] = 32'h00300113; w3[2] = 32'h002081B3;
    gaps = '{0, 2, 0, 1, 3, 0, 0, 0, 1, 0, 2, 0};

    // Reset then idle
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    rx_data = 8'hAA; rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_rx_ready", {31'b0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;
    chk("idle_no_we", we_cnt, 32'd0);

    // Single word with latency checks
    base = we_cnt;
    do_start(6'd1);
    chk("single_busy", {30'b0, busy, cpu_hold}, 32'd3);
    send_word(32'h00500093);
    rx_valid = 1'b0;
    chk("single_we", {31'b0, we}, 32'd1);
    chk("single_waddr", waddr, 32'd0);
    chk("single_wdata", wdata, 32'h00500093);
    tick();
    chk("single_done", {29'b0, done, busy, cpu_hold}, 32'b101);
    tick();
    chk("single_release", {29'b0, done, busy, cpu_hold}, 32'b000);
    chk("single_we_count", we_cnt - base, 32'd1);

    // Three words with idle gaps and waits across the write cycle
    base = we_cnt;
    do_start(6'd3);
    for (int i = 0; i < 12; i++) begin
      if (gaps[i] != 0) begin
        rx_valid = 1'b0;
        repeat (gaps[i]) tick();
      end
      fw = w3[i / 4];
      send_byte(fw[(i % 4) * 8 +: 8]);
    end
    rx_valid = 1'b0;
    repeat (4) tick();
    chk("three_we_count", we_cnt - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("three_waddr", wa_log[base + i], 32'(i * 4));
      chk("three_wdata", wd_log[base + i], w3[i]);
    end

    // Boundary counts
    base = we_cnt;
    do_start(6'd0);
    chk("zero_done_err", {30'b0, done, err}, 32'b10);
    tick();
    chk("zero_done_clear", {31'b0, done}, 32'd0);
    do_start(6'd33);
    chk("over_done_err", {29'b0, done, err, busy}, 32'b110);
    tick();
    chk("over_err_sticky", {30'b0, done, err}, 32'b01);
    chk("boundary_no_we", we_cnt - base, 32'd0);
    do_start(6'd1);
    chk("err_cleared", {30'b0, err, busy}, 32'b01);
    send_word(32'h12345678);
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("after_err_we", we_cnt - base, 32'd1);

    // Full depth with a start pulse mid-load
    base = we_cnt;
    do_start(6'd32);
    for (int i = 0; i < 32; i++) begin
      if (i == 11) begin
        rx_valid   = 1'b0;
        start      = 1'b1;
        word_count = 6'd1;
        tick();
        start = 1'b0;
        chk("midstart_busy", {30'b0, busy, rx_ready}, 32'b11);
      end
      send_word({8'hC3, 8'(i), 8'(~i), 8'(i * 3)});
    end
    rx_valid = 1'b0;
    chk("full_last_waddr", waddr, 32'h7C);
    tick();
    chk("full_done", {31'b0, done}, 32'd1);
    repeat (3) tick();
    chk("full_we_count", we_cnt - base, 32'd32);
    for (int i = 0; i < 32; i += 5) begin
      chk("full_waddr", wa_log[base + i], 32'(i * 4));
      chk("full_wdata", wd_log[base + i], {8'hC3, 8'(i), 8'(~i), 8'(i * 3)});
    end

    // Reset mid-load
    base = we_cnt;
    do_start(6'd2);
    send_word(32'hDEADBEEF);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    chk("midrst_busy", {30'b0, busy, cpu_hold}, 32'b11);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_we_count", we_cnt - base, 32'd1);
    do_start(6'd1);
    send_word(32'hCAFEF00D);
    rx_valid = 1'b0;
    chk("restart_waddr", waddr, 32'd0);
    chk("restart_wdata", wdata, 32'hCAFEF00D);
    repeat (3) tick();
    chk("restart_we_count", we_cnt - base, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory: it fills a writable instruction memory at run time instead of relying on a preloaded image. It accepts a byte stream over a valid/ready handshake, for example from a UART receiver. Bytes are assembled little-endian into 32-bit words and written to consecutive word addresses starting at byte address 0. While loading, the block holds the core in reset so the fetch stage cannot read a partially written program.

Parameters:
MEM_DEPTH, 32, instruction memory depth in 32-bit words
CNT_W, $clog2(MEM_DEPTH)+1, width of word_count (derived; must hold the value MEM_DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled in IDLE only
word_count  input  CNT_W  number of words to load; sampled on the start cycle
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
we  output  1  instruction memory write enable, one cycle per word
waddr  output  32  byte address of the write (word index << 2; bits [1:0] = 0)
wdata  output  32  assembled instruction word
busy  output  1  load in progress
cpu_hold  output  1  holds the core/PC in reset while high
done  output  1  one-cycle pulse at load completion
err  output  1  sticky: last start had word_count > MEM_DEPTH; cleared by the next accepted start

Behaviour:
- Reset values: rx_ready=0, we=0, waddr=0, wdata=0, busy=0, cpu_hold=0, done=0, err=0. FSM goes to IDLE; byte and word counters are cleared.
- All outputs are registered except rx_ready, which equals (state==RECV).
- Handshake: a byte transfers on any clock edge where rx_valid && rx_ready. rx_data must be held while rx_valid=1 && rx_ready=0. The loader never drops or duplicates a byte.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 and 0 < word_count <= MEM_DEPTH -> RECV. Latch the count, clear word_idx and byte_idx, set busy=1 and cpu_hold=1, clear err.
  - start=1 and word_count=0 -> DONE. No writes occur.
  - start=1 and word_count > MEM_DEPTH -> DONE with err=1. No writes occur.
- RECV:
  - Each accepted byte is written to assembly lane byte_idx (byte 0 -> bits [7:0], byte 3 -> bits [31:24]); byte_idx then increments.
  - On acceptance of the 4th byte (byte_idx==3) -> WRITE.
- WRITE (exactly one cycle):
  - we=1, waddr={word_idx,2'b00} zero-extended to 32 bits, wdata=assembled word. rx_ready=0.
  - Next state: DONE if word_idx+1 == count; otherwise word_idx++, byte_idx=0, -> RECV.
- DONE (one cycle): done=1, busy=0. cpu_hold stays 1 in this cycle and drops to 0 in the following cycle (back in IDLE).
- Latency: 4th byte of the last word accepted at edge N -> we high in cycle N+1 -> done high in cycle N+2 -> cpu_hold low in cycle N+3.
- start is ignored in every state except IDLE; no restart occurs mid-load.
- rx_valid outside RECV is ignored: no transfer, because rx_ready=0.
- Reset mid-load: immediate return to reset values. Words already written stay in memory; the partially assembled word is discarded. A new start begins again at address 0.
- With MEM_DEPTH=32 the word index never exceeds 31 (count is checked up front), so waddr never wraps.
- Throughput: at most one byte per cycle. Minimum of 5 cycles per word (4 RECV + 1 WRITE).

Test Plan:
- Reset then idle: reset high 3 cycles -> all outputs 0. rx_valid=1 with rx_data=8'hAA while IDLE -> rx_ready stays 0, no we.
- Single word: start, word_count=1, bytes 93,00,50,00 back-to-back -> one we with waddr=0, wdata=32'h00500093. done 2 cycles after the last byte. cpu_hold low 3 cycles after the last byte.
- Three words, random rx_valid gaps: words 32'h00500093, 32'h00300113, 32'h002081B3 -> we at waddr 0, 4, 8 with those data values, no extra we. rx_data held stable while rx_ready=0 is accepted exactly once.
- Boundary counts: word_count=0 -> done in the cycle after start, err=0, no we. word_count=33 -> done, err=1, no we. Next start with word_count=1 -> err clears.
- Full depth: word_count=32 -> last we at waddr=124 (32'h7C), then done. start pulsed mid-load -> ignored, exactly 32 writes.
- Reset mid-load: assert reset after 2 of 4 bytes of word 1 (word 0 already written) -> outputs return to 0, no further we. New start with word_count=1 -> write at waddr=0.
